// File: rtl/piso_shift_tx_pkg.sv
// Shared types and constants for the parallel-in / serial-out transmitter.
package piso_shift_tx_pkg;

    // Word length used when the instantiating level does not override it.
    localparam int unsigned DefaultWidth = 4;

    // Transmitter control states.
    typedef enum logic {
        StIdle  = 1'b0,
        StShift = 1'b1
    } state_e;

    // Bit-counter width for a given word length; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/piso_shift_tx_if.sv
// Load handshake, shift enable and serial output bundle of the transmitter.
interface piso_shift_tx_if
    import piso_shift_tx_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
);

    logic             load_valid;
    logic [WIDTH-1:0] din;
    logic             load_ready;
    logic             en;
    logic             SO;
    logic             so_valid;
    logic             so_last;
    logic             busy;

    // Word source / shift-enable owner.
    modport master (
        output load_valid,
        output din,
        output en,
        input  load_ready,
        input  SO,
        input  so_valid,
        input  so_last,
        input  busy
    );

    // The transmitter itself.
    modport slave (
        input  load_valid,
        input  din,
        input  en,
        output load_ready,
        output SO,
        output so_valid,
        output so_last,
        output busy
    );

endinterface

// File: rtl/piso_bit_counter.sv
// Down-counter tracking the bits left in the current word; load wins over decrement.
module piso_bit_counter #(
    parameter int unsigned CntW = 2
) (
    input  logic            clk,
    input  logic            clear,
    input  logic            load_i,
    input  logic [CntW-1:0] load_val_i,
    input  logic            dec_i,
    output logic            zero_o
);

    logic [CntW-1:0] count_q;
    logic [CntW-1:0] count_d;

    // Next count: reload, step down (saturating at zero) or hold.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - CntW'(1);
        end
    end

    // Count register, forced to zero by the asynchronous clear.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/piso_shift_tx.sv
// Parallel-in / serial-out transmitter with load handshake, shift stall and
// gap-free back-to-back words.
module piso_shift_tx
    import piso_shift_tx_pkg::*;
#(
    parameter int unsigned WIDTH     = DefaultWidth,
    parameter bit          MSB_FIRST = 1'b1
) (
    input logic           clk,
    input logic           clear,
    piso_shift_tx_if.slave bus
);

    localparam int unsigned     CntW    = cnt_width(WIDTH);
    localparam logic [CntW-1:0] LastIdx = CntW'(WIDTH - 1);

    state_e           state_q;
    state_e           state_d;
    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;

    logic cnt_load;
    logic cnt_dec;
    logic cnt_zero;
    logic load_ready;
    logic handshake;
    logic out_bit;

    // The final bit of a word is also the slot where the next word may load.
    assign load_ready = (state_q == StIdle) || (cnt_zero && bus.en);
    assign handshake  = bus.load_valid && load_ready;

    // Bit at the output end of the shift register.
    assign out_bit = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];

    piso_bit_counter #(
        .CntW (CntW)
    ) u_bit_counter (
        .clk        (clk),
        .clear      (clear),
        .load_i     (cnt_load),
        .load_val_i (LastIdx),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    // Next-state, shift-register and counter control.
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (handshake) begin
                    shreg_d  = bus.din;
                    cnt_load = 1'b1;
                    state_d  = StShift;
                end
            end

            StShift: begin
                // en low freezes everything, including a pending reload.
                if (bus.en) begin
                    if (!cnt_zero) begin
                        if (MSB_FIRST) begin
                            shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
                        end else begin
                            shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
                        end
                        cnt_dec = 1'b1;
                    end else if (handshake) begin
                        shreg_d  = bus.din;
                        cnt_load = 1'b1;
                    end else begin
                        shreg_d = '0;
                        state_d = StIdle;
                    end
                end
            end

            default: begin
                state_d = StIdle;
                shreg_d = '0;
            end
        endcase
    end

    // State and shift register, forced idle and empty by the asynchronous clear.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_q <= StIdle;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
        end
    end

    // Serial outputs are gated so nothing leaks out while idle.
    always_comb begin
        bus.SO       = 1'b0;
        bus.so_valid = 1'b0;
        bus.so_last  = 1'b0;
        bus.busy     = 1'b0;
        if (state_q == StShift) begin
            bus.SO       = out_bit;
            bus.so_valid = 1'b1;
            bus.so_last  = cnt_zero;
            bus.busy     = 1'b1;
        end
    end

    assign bus.load_ready = load_ready;

endmodule

// File: tb/tb_piso_shift_tx.sv
// Scoreboard bench: one MSB-first and one LSB-first transmitter driven in lockstep.
module tb_piso_shift_tx;

    logic clk;
    logic clear;

    int unsigned n_chk;
    int unsigned n_pass;
    int unsigned vcnt_m;
    int unsigned vcnt_l;
    int unsigned v0_m;
    int unsigned v0_l;

    // Each entry is {expected SO, expected so_last}.
    logic [1:0] q_m[$];
    logic [1:0] q_l[$];

    piso_shift_tx_if #(.WIDTH(4)) bus_m ();
    piso_shift_tx_if #(.WIDTH(4)) bus_l ();

    piso_shift_tx #(
        .WIDTH     (4),
        .MSB_FIRST (1'b1)
    ) dut_m (
        .clk   (clk),
        .clear (clear),
        .bus   (bus_m)
    );

    piso_shift_tx #(
        .WIDTH     (4),
        .MSB_FIRST (1'b0)
    ) dut_l (
        .clk   (clk),
        .clear (clear),
        .bus   (bus_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic lv, input logic [3:0] d, input logic e);
        bus_m.load_valid = lv;
        bus_m.din        = d;
        bus_m.en         = e;
        bus_l.load_valid = lv;
        bus_l.din        = d;
        bus_l.en         = e;
    endtask

    task automatic push_word(input logic [3:0] d);
        for (int i = 3; i >= 0; i--) q_m.push_back({d[i], (i == 0)});
        for (int i = 0; i < 4; i++) q_l.push_back({d[i], (i == 3)});
    endtask

    task automatic snap();
        v0_m = vcnt_m;
        v0_l = vcnt_l;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_m_busy"},  bus_m.busy,       0);
        check({tag, "_m_valid"}, bus_m.so_valid,   0);
        check({tag, "_m_so"},    bus_m.SO,         0);
        check({tag, "_m_last"},  bus_m.so_last,    0);
        check({tag, "_m_ready"}, bus_m.load_ready, 1);
        check({tag, "_l_busy"},  bus_l.busy,       0);
        check({tag, "_l_valid"}, bus_l.so_valid,   0);
        check({tag, "_l_so"},    bus_l.SO,         0);
        check({tag, "_l_last"},  bus_l.so_last,    0);
        check({tag, "_l_ready"}, bus_l.load_ready, 1);
    endtask

    task automatic check_count(input string tag, input int unsigned exp);
        check({tag, "_m_cnt"}, vcnt_m - v0_m, exp);
        check({tag, "_l_cnt"}, vcnt_l - v0_l, exp);
    endtask

    // Compare each valid serial bit with the scoreboard head; a bit retires when en=1.
    task automatic mon_step();
        if (!clear) begin
            if (bus_m.so_valid) begin
                vcnt_m++;
                check("m_sb_has_bit", (q_m.size() != 0), 1);
                if (q_m.size() != 0) begin
                    check("m_so",   bus_m.SO,      q_m[0][1]);
                    check("m_last", bus_m.so_last, q_m[0][0]);
                    if (bus_m.en) void'(q_m.pop_front());
                end
            end
            if (bus_l.so_valid) begin
                vcnt_l++;
                check("l_sb_has_bit", (q_l.size() != 0), 1);
                if (q_l.size() != 0) begin
                    check("l_so",   bus_l.SO,      q_l[0][1]);
                    check("l_last", bus_l.so_last, q_l[0][0]);
                    if (bus_l.en) void'(q_l.pop_front());
                end
            end
        end
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        vcnt_m = 0;
        vcnt_l = 0;
        v0_m   = 0;
        v0_l   = 0;

        // Reset with a word offered: nothing may be captured.
        clear = 1'b1;
        drive(1'b1, 4'hF, 1'b1);
        fork
            forever begin
                @(negedge clk);
                mon_step();
            end
            begin
                #50000;
                $display("FAIL watchdog: got timeout expected finish");
                $fatal(1, "watchdog expired");
            end
        join_none
        #3 check_idle("rst_a");
        #5 check_idle("rst_b");
        #2;
        clear = 1'b0;
        drive(1'b0, 4'h0, 1'b1);
        cyc();
        check_idle("post_rst");

        // en is ignored while idle.
        drive(1'b0, 4'h0, 1'b0);
        cyc();
        check_idle("idle_en0");
        drive(1'b0, 4'h0, 1'b1);

        // Single word 1011.
        snap();
        drive(1'b1, 4'b1011, 1'b1);
        check("single_m_ready", bus_m.load_ready, 1);
        push_word(4'b1011);
        cyc();
        drive(1'b0, 4'h0, 1'b1);
        check("single_m_first_valid", bus_m.so_valid, 1);
        check("single_l_first_valid", bus_l.so_valid, 1);
        repeat (3) cyc();
        check("single_m_last_on4", bus_m.so_last, 1);
        check("single_l_last_on4", bus_l.so_last, 1);
        cyc();
        check_idle("single_end");
        check_count("single", 4);

        // Back-to-back 1100 then 0011 with load_valid held.
        snap();
        drive(1'b1, 4'b1100, 1'b1);
        push_word(4'b1100);
        cyc();
        drive(1'b1, 4'b0011, 1'b1);
        push_word(4'b0011);
        cyc();
        check("b2b_m_not_ready", bus_m.load_ready, 0);
        check("b2b_l_not_ready", bus_l.load_ready, 0);
        repeat (2) cyc();
        check("b2b_m_ready_last", bus_m.load_ready, 1);
        check("b2b_l_ready_last", bus_l.load_ready, 1);
        cyc();
        drive(1'b0, 4'h0, 1'b1);
        check("b2b_m_no_gap", bus_m.so_valid, 1);
        repeat (4) cyc();
        check_idle("b2b_end");
        check_count("b2b", 8);

        // Stall for 3 cycles after the second bit of 1010.
        snap();
        drive(1'b1, 4'b1010, 1'b1);
        push_word(4'b1010);
        cyc();
        drive(1'b0, 4'h0, 1'b1);
        cyc();
        drive(1'b0, 4'h0, 1'b0);
        repeat (3) cyc();
        check("stall_m_not_ready", bus_m.load_ready, 0);
        check("stall_m_busy", bus_m.busy, 1);
        drive(1'b0, 4'h0, 1'b1);
        repeat (3) cyc();
        check_idle("stall_end");
        check_count("stall", 7);

        // Clear two bits into 1111, then send 0001 cleanly.
        snap();
        drive(1'b1, 4'hF, 1'b1);
        push_word(4'hF);
        cyc();
        drive(1'b0, 4'h0, 1'b1);
        repeat (2) cyc();
        check_count("mid", 2);
        clear = 1'b1;
        q_m.delete();
        q_l.delete();
        #1 check_idle("clear_now");
        cyc();
        check_idle("clear_held");
        clear = 1'b0;
        snap();
        drive(1'b1, 4'b0001, 1'b1);
        check("after_clr_m_ready", bus_m.load_ready, 1);
        push_word(4'b0001);
        cyc();
        drive(1'b0, 4'h0, 1'b1);
        check("after_clr_m_valid", bus_m.so_valid, 1);
        repeat (4) cyc();
        check_idle("after_clr_end");
        check_count("after_clr", 4);

        check("m_sb_drained", q_m.size(), 0);
        check("l_sb_drained", q_l.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/piso_shift_tx.md
PISO_SHIFT_TX -- requirements
Module: piso_shift_tx

Interface
REQ-001 Parameter WIDTH, default 4, word length in bits (legal range 2..32).
REQ-002 Parameter MSB_FIRST, default 1; 1 = bit WIDTH-1 is sent first, 0 = bit 0 is sent first.
REQ-003 Port clk, input, 1, single clock; all state changes on rising edge.
REQ-004 Port clear, input, 1, asynchronous active-high reset.
REQ-005 Port load_valid, input, 1, parallel word on din is offered.
REQ-006 Port din, input, WIDTH, parallel word to serialize.
REQ-007 Port load_ready, output, 1, block accepts din this cycle.
REQ-008 Port en, input, 1, shift enable; low freezes an in-progress word.
REQ-009 Port SO, output, 1, serial data out.
REQ-010 Port so_valid, output, 1, SO carries a valid bit this cycle.
REQ-011 Port so_last, output, 1, current SO bit is the final bit of the word.
REQ-012 Port busy, output, 1, a word is in progress.

Function
REQ-013 States: IDLE and SHIFT only.
REQ-014 Load handshake fires on a rising edge where load_valid=1 and load_ready=1; din is captured into the shift register and the bit counter is loaded with WIDTH-1.
REQ-015 load_ready=1 in IDLE; in SHIFT, load_ready=1 only when the counter is 0 and en=1; otherwise load_ready=0.
REQ-016 IDLE -> SHIFT on handshake; IDLE holds otherwise.
REQ-017 In SHIFT: SO = shift-register MSB (MSB_FIRST=1) or LSB (MSB_FIRST=0), combinationally from the register; so_valid=1; busy=1.
REQ-018 In SHIFT with en=1 and counter>0: shift the register one position toward the output end (zero fill) and decrement the counter.
REQ-019 In SHIFT with en=0: register, counter and state hold; SO, so_valid and so_last are unchanged.
REQ-020 so_last=1 in SHIFT when the counter is 0.
REQ-021 Counter 0, en=1, no handshake: SHIFT -> IDLE.
REQ-022 Counter 0, en=1, handshake (back-to-back): state remains SHIFT, the new word loads, and the counter reloads to WIDTH-1, with no idle gap between words.
REQ-023 Latency: the first bit appears on SO in the cycle after the handshake edge; a word occupies exactly WIDTH enabled SHIFT cycles.
REQ-024 In IDLE: SO=0, so_valid=0, so_last=0, busy=0; en is ignored.
REQ-025 load_valid while load_ready=0 is ignored, with no capture and no error; din need not be held.

Reset
REQ-026 clear=1 asynchronously forces IDLE, shift register to 0 and counter to 0; outputs immediately become SO=0, so_valid=0, so_last=0, busy=0, load_ready=1.
REQ-027 clear asserted mid-word aborts the word; no partial bits are emitted after clear.
REQ-028 First handshake is possible on the first rising edge after clear deasserts.

Structure
REQ-029 A shared package holds the state typedef (IDLE, SHIFT) and the default WIDTH constant.
REQ-030 One sub-module, piso_bit_counter: a down-counter with load, decrement-enable and zero flag, width $clog2(WIDTH).
REQ-031 Shift register, FSM and output logic reside in piso_shift_tx; no other sub-modules.

Verification
REQ-032 Reset: clear=1 for 10 time units with load_valid=1 and din=4'hF -> busy=0, SO=0, load_ready=1 throughout; no capture.
REQ-033 Single word: WIDTH=4, MSB_FIRST=1, din=4'b1011 -> SO=1,0,1,1 on 4 consecutive cycles, with so_last only on the 4th, then IDLE.
REQ-034 LSB-first: MSB_FIRST=0, din=4'b1011 -> SO=1,1,0,1.
REQ-035 Back-to-back: 4'b1100 then 4'b0011, with load_valid held -> 8 contiguous so_valid cycles giving SO=1,1,0,0,0,0,1,1.
REQ-036 Stall: en=0 for 3 cycles after the 2nd bit of 4'b1010 -> SO holds 0 for 3 cycles, then 1,0 resume; total so_valid cycles = 7.
REQ-037 Mid-word clear: assert clear after 2 bits of 4'b1111 -> SO=0 and busy=0 immediately; next word 4'b0001 is sent cleanly as 0,0,0,1.
